// File: rtl/multi_bbox_tracker.sv
// ============================================================================
//  Module   : multi_bbox_tracker
//  Purpose  : Per-channel bounding box, pixel count and validity over one
//             video frame, published on frame end. The optional ROI filter is
//             enabled by defining BBOX_ROI_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_bbox_tracker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int NUM_CH   = 4,
    parameter int CW       = 16,
    parameter int CNT_W    = 20,
    parameter int MIN_PIX  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_sync,
    input  logic                      v_sync,
    input  logic [NUM_CH-1:0]         is_feature,
`ifdef BBOX_ROI_EN
    input  logic [CW-1:0]             roi_x0,
    input  logic [CW-1:0]             roi_x1,
    input  logic [CW-1:0]             roi_y0,
    input  logic [CW-1:0]             roi_y1,
`endif
    output logic [NUM_CH*CW-1:0]      bbox_x_min,
    output logic [NUM_CH*CW-1:0]      bbox_x_max,
    output logic [NUM_CH*CW-1:0]      bbox_y_min,
    output logic [NUM_CH*CW-1:0]      bbox_y_max,
    output logic [NUM_CH*CNT_W-1:0]   pix_count,
    output logic [NUM_CH-1:0]         obj_valid,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CW-1:0]    c_X_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]    c_Y_END   = CW'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_MIN_PIX = CNT_W'(MIN_PIX);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          w_frame_done;
    logic          w_latch;
    logic          w_run;
    logic          w_roi_ok;
    logic          w_accept;
    logic          w_in_frame;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [15:0]   r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_SYNC:   if (!v_sync) w_next_state = S_IDLE;
            S_IDLE:   if (v_sync)  w_next_state = S_ACTIVE;
            S_ACTIVE: if (!v_sync) w_next_state = S_DONE;
            default:  w_next_state = v_sync ? S_ACTIVE : S_IDLE;
        endcase
    end

    // DONE with v_sync high is already the first cycle of the next frame.
    always_comb begin
        w_frame_done = (r_state == S_DONE);
        w_latch      = (r_state == S_ACTIVE) && !v_sync;
        w_run        = ((r_state == S_ACTIVE) || (r_state == S_DONE))
                       && v_sync && h_sync && w_in_frame;
    end

    assign w_in_frame = (r_y < c_Y_END);

`ifdef BBOX_ROI_EN
    assign w_roi_ok = (r_x >= roi_x0) && (r_x <= roi_x1)
                   && (r_y >= roi_y0) && (r_y <= roi_y1);
`else
    assign w_roi_ok = 1'b1;
`endif

    assign w_accept = w_run && w_roi_ok;

    always_ff @(posedge clk) begin
        if (rst || !v_sync) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_run) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + CW'(1);
            end else begin
                r_x <= r_x + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_latch) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_done  = w_frame_done;
    assign frame_count = r_frame_count;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             r_found;
        logic [CW-1:0]    r_xmin, r_xmax, r_ymin, r_ymax;
        logic [CNT_W-1:0] r_cnt;
        logic [CW-1:0]    r_out_xmin, r_out_xmax, r_out_ymin, r_out_ymax;
        logic [CNT_W-1:0] r_out_cnt;
        logic             r_out_valid;
        logic             w_hit;
        logic             w_valid;

        assign w_hit   = w_accept && is_feature[c];
        assign w_valid = r_found && (r_cnt >= c_MIN_PIX);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_found     <= 1'b0;
                r_xmin      <= '0;
                r_xmax      <= '0;
                r_ymin      <= '0;
                r_ymax      <= '0;
                r_cnt       <= '0;
                r_out_xmin  <= '0;
                r_out_xmax  <= '0;
                r_out_ymin  <= '0;
                r_out_ymax  <= '0;
                r_out_cnt   <= '0;
                r_out_valid <= 1'b0;
            end else if (w_latch) begin
                r_out_cnt   <= r_cnt;
                r_out_valid <= w_valid;
                r_out_xmin  <= w_valid ? r_xmin : '0;
                r_out_xmax  <= w_valid ? r_xmax : '0;
                r_out_ymin  <= w_valid ? r_ymin : '0;
                r_out_ymax  <= w_valid ? r_ymax : '0;
                r_found     <= 1'b0;
                r_xmin      <= '0;
                r_xmax      <= '0;
                r_ymin      <= '0;
                r_ymax      <= '0;
                r_cnt       <= '0;
            end else if (w_hit) begin
                r_found <= 1'b1;
                r_cnt   <= (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                if (!r_found) begin
                    r_xmin <= r_x;
                    r_xmax <= r_x;
                    r_ymin <= r_y;
                    r_ymax <= r_y;
                end else begin
                    if (r_x < r_xmin) r_xmin <= r_x;
                    if (r_x > r_xmax) r_xmax <= r_x;
                    if (r_y < r_ymin) r_ymin <= r_y;
                    if (r_y > r_ymax) r_ymax <= r_y;
                end
            end
        end

        assign bbox_x_min[c*CW +: CW]       = r_out_xmin;
        assign bbox_x_max[c*CW +: CW]       = r_out_xmax;
        assign bbox_y_min[c*CW +: CW]       = r_out_ymin;
        assign bbox_y_max[c*CW +: CW]       = r_out_ymax;
        assign pix_count[c*CNT_W +: CNT_W]  = r_out_cnt;
        assign obj_valid[c]                 = r_out_valid;
    end

endmodule

`default_nettype wire
